read_ram_controller: RTL and testbench
======================================

Name: read_ram_controller

Overview:
- Reader counterpart of the camera-side RAM write controller.
- Once a frame buffer is filled, it reads a byte range from the shared 2048×8 frame RAM and serialises it onto the MII transmit nibble bus.
- Each frame is preamble + SFD, then payload nibbles low nibble first, then an inter-frame gap.
- Runs in the Ethernet clock domain and signals completion on eth_finish.

Parameters:
- ADDR_W, 11, RAM address width; the RAM depth is 2**ADDR_W bytes.
- IFG_CYCLES, 24, inter-frame gap length in clk cycles (12 byte times).

Ports:
- clk  in  1  Ethernet clock (25 MHz), one nibble per cycle.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to send a frame; sampled only in IDLE.
- start_addr  in  ADDR_W  first RAM address of the payload; sampled with start.
- byte_cnt  in  ADDR_W+1  payload length in bytes, 1..2048; sampled with start.
- ram_en  out  1  RAM read enable.
- ram_addr  out  ADDR_W  RAM read address.
- ram_data_out  in  8  RAM read data, valid the cycle after ram_en.
- MII  out  4  transmit nibble.
- MII_EN  out  1  transmit enable.
- busy  out  1  high in every state except IDLE.
- eth_finish  out  1  one-cycle pulse at end of frame.
- FSM_state  out  2  current state: 0 IDLE, 1 PRE, 2 DATA, 3 GAP.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- Reset asserted mid-frame drops MII_EN immediately (asynchronously). No eth_finish is produced for the aborted frame.
- IDLE:
  - start=1 with byte_cnt≠0: latch start_addr and byte_cnt, go to PRE on the next edge.
  - start=1 with byte_cnt=0: ignored; stay in IDLE, no pulse.
  - Out-of-range byte_cnt (>2048): clamped to 2048.
- PRE:
  - 16 cycles: MII=0x5 for 15 cycles, then 0xD (SFD 0xD5, low nibble first).
  - MII_EN=1 from the first PRE cycle.
- Prefetch:
  - ram_en pulses one cycle with ram_addr=start_addr in the 15th PRE cycle.
  - Data is captured into a byte register at the first DATA cycle.
- DATA:
  - Each byte occupies 2 cycles: MII=byte[3:0], then byte[7:4].
  - During the low-nibble cycle of byte k, ram_en=1 and ram_addr=start_addr+k+1, truncated mod 2**ADDR_W so the address wraps 2047→0.
  - No read is issued after the last byte; ram_en is otherwise 0.
- Frame length: the first DATA nibble appears 17 cycles after the start edge. MII_EN stays high exactly 16+2·byte_cnt cycles.
- End of frame:
  - The cycle after the last nibble: MII_EN=0, MII=0, eth_finish=1 for one cycle, state→GAP.
- GAP:
  - Lasts IFG_CYCLES cycles, then return to IDLE.
  - start during GAP is ignored, not queued.
- start while busy: ignored.
- ram_data_out is consumed only in the cycle after the controller's own ram_en.
- MII is 0 whenever MII_EN=0.

Optional Feature:
- Macro: READ_RAM_CONTROLLER_FCS_EN.
- Defined:
  - After the payload, the FCS is appended: 8 nibbles of the IEEE 802.3 CRC-32 over the payload bytes only.
  - CRC parameters: init 0xFFFFFFFF, reflected, final complement, transmitted least-significant nibble first.
  - Frame length becomes 16+2·byte_cnt+8 cycles; FSM_state stays 2 during FCS.
  - eth_finish follows the last FCS nibble.
- Undefined: no CRC logic; the frame ends after the payload.

Decomposition:
- Package eth_tx_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_PRE=2'd1, ST_DATA=2'd2, ST_GAP=2'd3;
  - PREAMBLE_NIBBLE=4'h5, SFD_HI_NIBBLE=4'hD;
  - CRC32_POLY=32'hEDB88320, CRC32_RESIDUE_INIT.
- One sub-module, crc32_nibble: a combinational-update/registered CRC over 4-bit input with a clear input. It is instantiated only under READ_RAM_CONTROLLER_FCS_EN.

Test Plan:
- Basic frame:
  - Stimulus: RAM[0..3]=0x12,0x34,0x56,0x78; start_addr=0, byte_cnt=4.
  - Required: MII sequence is 5 (×15), D, 2,1,4,3,6,5,8,7. MII_EN high 24 cycles. eth_finish one pulse at cycle 25 after start. FSM_state sequence 1→2→3→0.
- Wrap-around:
  - Stimulus: start_addr=2046, byte_cnt=4.
  - Required: ram_addr sequence 2046, 2047, 0, 1; exactly 4 ram_en pulses.
- Boundaries:
  - Stimulus: byte_cnt=0.
  - Required: no MII_EN, no eth_finish, busy stays 0.
  - Stimulus: byte_cnt=1 with byte 0xA5.
  - Required: nibbles 5, A after SFD; MII_EN high 18 cycles.
- start while busy:
  - Stimulus: start pulses during DATA and during GAP.
  - Required: ignored. A start 1 cycle after GAP exits is accepted. Gap between MII_EN fall and next rise ≥ IFG_CYCLES+1.
- Reset mid-frame:
  - Stimulus: reset low during DATA byte 2.
  - Required: MII_EN=0 and MII=0 without a clock edge. No eth_finish. After release, a new start produces a full, correct frame.
- FCS (with READ_RAM_CONTROLLER_FCS_EN defined):
  - Stimulus: payload ASCII "123456789".
  - Required: FCS bytes on the wire are 0x26,0x39,0xF4,0xCB, i.e. nibbles 6,2,9,3,4,F,B,C. MII_EN high 42 cycles.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared constants for the MII frame transmitter: state encoding, preamble
// nibbles and the reflected CRC-32 step used when the FCS is appended.
package eth_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam logic [3:0]  PREAMBLE_NIBBLE    = 4'h5;
  localparam logic [3:0]  SFD_HI_NIBBLE      = 4'hD;
  localparam logic [31:0] CRC32_POLY         = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE_INIT = 32'hFFFFFFFF;
  localparam int          PRE_CYCLES         = 16;
  localparam int          FCS_NIBBLES        = 8;

  // Reflected CRC-32 advanced by one nibble, least-significant bit first.
  function automatic logic [31:0] crc32_step_nibble(input logic [31:0] crc,
                                                    input logic [3:0]  nib);
    logic [31:0] c;
    c = crc ^ {28'd0, nib};
    for (int i = 0; i < 4; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_nibble.sv
// Registered CRC-32 accumulator fed one nibble per enabled cycle; crc_next is
// the combinational value the register would take with the current nibble.
module crc32_nibble
  import eth_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [3:0]  nibble,
  output logic [31:0] crc_next
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_next = crc32_step_nibble(crc_q, nibble);
    crc_d    = crc_q;
    if (clear) begin
      crc_d = CRC32_RESIDUE_INIT;
    end else if (en) begin
      crc_d = crc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC32_RESIDUE_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

endmodule

// File: rtl/read_ram_controller.sv
// Streams a byte range of the frame RAM onto MII: preamble+SFD, payload low
// nibble first, then an inter-frame gap. READ_RAM_CONTROLLER_FCS_EN appends CRC-32.
module read_ram_controller
  import eth_tx_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int IFG_CYCLES = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   byte_cnt,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data_out,
  output logic [3:0]        MII,
  output logic              MII_EN,
  output logic              busy,
  output logic              eth_finish,
  output logic [1:0]        FSM_state
);

  localparam int               LEN_W   = ADDR_W + 1;
  localparam int               CNT_W   = 8;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**ADDR_W);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              hi_q, hi_d;
  logic [3:0]        byte_hi_q, byte_hi_d;
  logic [3:0]        mii_q, mii_d;
  logic              mii_en_q, mii_en_d;
  logic              ram_en_q, ram_en_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              finish_q, finish_d;
  logic              frame_done;
  logic              last_byte;

`ifdef READ_RAM_CONTROLLER_FCS_EN
  logic        fcs_q, fcs_d;
  logic [31:0] fcs_sr_q, fcs_sr_d;
  logic [31:0] crc_next;
  logic [31:0] crc_fin;

  crc32_nibble u_crc (
    .clk      (clk),
    .rst_n    (reset),
    .clear    (state_q == ST_PRE),
    .en       ((state_q == ST_DATA) && !fcs_q),
    .nibble   (mii_q),
    .crc_next (crc_next)
  );
`endif

  // start is a one-cycle request with no ready: it is honoured only when
  // FSM_state is IDLE and silently dropped otherwise (callers watch busy).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    idx_d      = idx_q;
    hi_d       = hi_q;
    byte_hi_d  = byte_hi_q;
    mii_d      = mii_q;
    mii_en_d   = mii_en_q;
    ram_en_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    finish_d   = 1'b0;
    frame_done = 1'b0;
    last_byte  = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
`ifdef READ_RAM_CONTROLLER_FCS_EN
    fcs_d      = fcs_q;
    fcs_sr_d   = fcs_sr_q;
    crc_fin    = ~crc_next;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start && (byte_cnt != '0)) begin
          state_d  = ST_PRE;
          cnt_d    = '0;
          addr_d   = start_addr;
          len_d    = (byte_cnt > MAX_LEN) ? MAX_LEN : byte_cnt;
          mii_d    = PREAMBLE_NIBBLE;
          mii_en_d = 1'b1;
        end
      end

      ST_PRE: begin
        if (cnt_q == CNT_W'(PRE_CYCLES - 1)) begin
          // Prefetched byte 0 is on ram_data_out now; issue the read for byte 1.
          state_d    = ST_DATA;
          idx_d      = '0;
          hi_d       = 1'b0;
          mii_d      = ram_data_out[3:0];
          byte_hi_d  = ram_data_out[7:4];
          ram_en_d   = (len_q > LEN_W'(1));
          ram_addr_d = addr_q + ADDR_W'(1);
`ifdef READ_RAM_CONTROLLER_FCS_EN
          fcs_d      = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          mii_d = (cnt_q == CNT_W'(PRE_CYCLES - 2)) ? SFD_HI_NIBBLE : PREAMBLE_NIBBLE;
          if (cnt_q == CNT_W'(PRE_CYCLES - 3)) begin
            ram_en_d   = 1'b1;
            ram_addr_d = addr_q;
          end
        end
      end

      ST_DATA: begin
`ifdef READ_RAM_CONTROLLER_FCS_EN
        if (fcs_q) begin
          if (cnt_q == CNT_W'(FCS_NIBBLES - 1)) begin
            frame_done = 1'b1;
          end else begin
            cnt_d    = cnt_q + CNT_W'(1);
            mii_d    = fcs_sr_q[7:4];
            fcs_sr_d = fcs_sr_q >> 4;
          end
        end else
`endif
        if (!hi_q) begin
          hi_d  = 1'b1;
          mii_d = byte_hi_q;
        end else if (last_byte) begin
`ifdef READ_RAM_CONTROLLER_FCS_EN
          fcs_d    = 1'b1;
          cnt_d    = '0;
          fcs_sr_d = crc_fin;
          mii_d    = crc_fin[3:0];
`else
          frame_done = 1'b1;
`endif
        end else begin
          // Byte idx+1 arrives now; fetch idx+2 if the payload still has it.
          hi_d       = 1'b0;
          idx_d      = idx_q + ADDR_W'(1);
          mii_d      = ram_data_out[3:0];
          byte_hi_d  = ram_data_out[7:4];
          ram_en_d   = (({1'b0, idx_q} + LEN_W'(2)) < len_q);
          ram_addr_d = addr_q + idx_q + ADDR_W'(2);
        end
      end

      ST_GAP: begin
        if (cnt_q == CNT_W'(IFG_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (frame_done) begin
      state_d  = ST_GAP;
      cnt_d    = '0;
      mii_d    = 4'h0;
      mii_en_d = 1'b0;
      finish_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      hi_q       <= 1'b0;
      byte_hi_q  <= '0;
      mii_q      <= '0;
      mii_en_q   <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
      finish_q   <= 1'b0;
`ifdef READ_RAM_CONTROLLER_FCS_EN
      fcs_q      <= 1'b0;
      fcs_sr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      hi_q       <= hi_d;
      byte_hi_q  <= byte_hi_d;
      mii_q      <= mii_d;
      mii_en_q   <= mii_en_d;
      ram_en_q   <= ram_en_d;
      ram_addr_q <= ram_addr_d;
      finish_q   <= finish_d;
`ifdef READ_RAM_CONTROLLER_FCS_EN
      fcs_q      <= fcs_d;
      fcs_sr_q   <= fcs_sr_d;
`endif
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_addr   = ram_addr_q;
  assign MII        = mii_q;
  assign MII_EN     = mii_en_q;
  assign eth_finish = finish_q;
  assign FSM_state  = state_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_read_ram_controller.sv
// Bench for read_ram_controller: builds each expected wire frame from the RAM
// image and compares every cycle of MII, enables, reads, state and the gap.
module tb_read_ram_controller;

  localparam int ADDR_W = 11;
  localparam int IFG    = 24;
  localparam int DEPTH  = 2048;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   byte_cnt;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data_out;
  logic [3:0]        MII;
  logic              MII_EN;
  logic              busy;
  logic              eth_finish;
  logic [1:0]        FSM_state;

  logic [7:0] mem [DEPTH];
  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  read_ram_controller #(.ADDR_W(ADDR_W), .IFG_CYCLES(IFG)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start),
    .start_addr   (start_addr),
    .byte_cnt     (byte_cnt),
    .ram_en       (ram_en),
    .ram_addr     (ram_addr),
    .ram_data_out (ram_data_out),
    .MII          (MII),
    .MII_EN       (MII_EN),
    .busy         (busy),
    .eth_finish   (eth_finish),
    .FSM_state    (FSM_state)
  );

  // synchronous-read frame RAM
  always @(posedge clk) begin
    if (ram_en) ram_data_out <= mem[ram_addr];
  end

  // MII_EN low-time monitor
  int neg_cnt = 0, fall_at = 0, last_gap = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    neg_cnt++;
    if (prev_en && !MII_EN) fall_at = neg_cnt;
    if (!prev_en && MII_EN) last_gap = neg_cnt - fall_at;
    prev_en = MII_EN;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference: preamble, SFD, payload nibbles low first, optional FCS
  task automatic build_frame(input int a, input int n);
    logic [31:0] crc;
    logic [7:0]  b;
    exp_q.delete();
    repeat (15) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    crc = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) begin
      b = mem[(a + k) % DEPTH];
      exp_q.push_back(b[3:0]);
      exp_q.push_back(b[7:4]);
      crc = crc ^ {24'd0, b};
      for (int j = 0; j < 8; j++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
`ifdef READ_RAM_CONTROLLER_FCS_EN
    crc = ~crc;
    for (int i = 0; i < 8; i++) exp_q.push_back(crc[4*i +: 4]);
`endif
  endtask

  // driver + per-cycle scoreboard for one frame request
  task automatic send_frame(input int a, input int n_req, input int inj_data,
                            input bit inj_gap, input int abort_at);
    int n, len, last, reads, k, exp_state, inj2, exp_addr;
    bit exp_ren, fin_seen;
    n = (n_req > DEPTH) ? DEPTH : n_req;
    build_frame(a, n);
    len   = exp_q.size();
    last  = len + IFG + 1;
    inj2  = inj_gap ? len + IFG : -1;
    reads = 0;
    start = 1'b1;
    start_addr = a[ADDR_W-1:0];
    byte_cnt   = n_req[ADDR_W:0];
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      check_eq("mii_en", MII_EN, c <= len);
      check_eq("mii", MII, (c <= len) ? exp_q[c-1] : 4'h0);
      check_eq("eth_finish", eth_finish, c == len + 1);
      exp_state = (c <= 16) ? 1 : (c <= len) ? 2 : (c <= len + IFG) ? 3 : 0;
      check_eq("fsm_state", FSM_state, exp_state);
      check_eq("busy", busy, exp_state != 0);
      k = (c - 17) / 2;
      exp_ren = (c == 15) || (c >= 17 && ((c - 17) % 2 == 0) && k <= n - 2);
      exp_addr = (c == 15) ? a : (a + k + 1) % DEPTH;
      check_eq("ram_en", ram_en, exp_ren);
      if (exp_ren) check_eq("ram_addr", ram_addr, exp_addr);
      if (ram_en) reads++;
      if (c == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_mii_en", MII_EN, 0);
        check_eq("abort_mii", MII, 0);
        check_eq("abort_busy", busy, 0);
        fin_seen = 1'b0;
        repeat (3) begin @(negedge clk); fin_seen |= eth_finish; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); fin_seen |= eth_finish; end
        check_eq("abort_no_finish", fin_seen, 0);
        return;
      end
      if (c != last) begin
        start = (c == inj_data) || (c == inj2);
        if (start) begin
          start_addr = ADDR_W'($urandom);
          byte_cnt   = (ADDR_W+1)'($urandom_range(1, 8));
        end
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    check_eq("read_count", reads, n);
  endtask

  initial begin
    int busy_seen;
    string s;
    rst_n = 1'b0;
    start = 1'b0;
    start_addr = '0;
    byte_cnt = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    #2;
    check_eq("rst_mii", MII, 0);
    check_eq("rst_mii_en", MII_EN, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_finish", eth_finish, 0);
    check_eq("rst_state", FSM_state, 0);
    check_eq("rst_ram_en", ram_en, 0);
    check_eq("rst_ram_addr", ram_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic frame, then a back-to-back wrap-around frame
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
    send_frame(0, 4, 0, 1'b0, 0);
    send_frame(2046, 4, 0, 1'b0, 0);
    check_eq("ifg_gap", last_gap, IFG + 1);

    // single byte
    mem[100] = 8'hA5;
    send_frame(100, 1, 0, 1'b0, 0);

    // zero-length request is ignored
    start = 1'b1; start_addr = 11'd5; byte_cnt = '0;
    @(posedge clk);
    #1 start = 1'b0;
    busy_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy || MII_EN || eth_finish) busy_seen++;
    end
    check_eq("zero_len_idle", busy_seen, 0);

    // starts during DATA and in the last GAP cycle are dropped
    send_frame(300, 6, 20, 1'b1, 0);
    send_frame(500, 3, 18, 1'b1, 0);
    check_eq("ifg_after_busy_start", last_gap, IFG + 1);

    // reset during byte 2 low nibble, then a clean frame
    send_frame(700, 6, 0, 1'b0, 21);
    send_frame(700, 6, 0, 1'b0, 0);

    // oversize length clamps to the full RAM
    send_frame(1000, 3000, 0, 1'b0, 0);

    // randomized frames
    repeat (6) begin
      send_frame($urandom_range(0, DEPTH - 1), $urandom_range(1, 24),
                 $urandom_range(17, 40), 1'($urandom_range(0, 1)), 0);
    end

    // "123456789" payload (FCS check value when the CRC is enabled)
    s = "123456789";
    for (int i = 0; i < 9; i++) mem[1200 + i] = s[i];
    send_frame(1200, 9, 0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
